// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data cache memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_TURN   = 2'd3
  } arb_state_e;

  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [3:0] SEL_ALL   = 4'hF;
  localparam logic       GNT_I     = 1'b0;
  localparam logic       GNT_D     = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between icache and dcache requests.
// ARB_RR_EN selects round-robin on ties; otherwise the dcache wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
`ifdef ARB_RR_EN
  input  logic last_grant,
`endif
  output logic valid,
  output logic gnt
);
  always_comb begin
    valid = req_i | req_d;
    gnt   = req_d ? GNT_D : GNT_I;
`ifdef ARB_RR_EN
    // On a tie, hand the slave to whoever was not served last.
    if (req_i && req_d) gnt = ~last_grant;
`endif
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// Two-master (icache/dcache) to one-slave memory arbiter, one access in flight.
// Build option ARB_RR_EN: round-robin tie-break instead of dcache priority.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_strobe,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  input  logic          d_strobe,
  input  logic          d_rw,
  input  logic [AW-1:0] d_addr,
  input  logic [1:0]    d_size,
  input  logic [3:0]    d_sel,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  input  logic          flush,
  output logic [AW-1:0] mem_a,
  output logic          mem_access,
  output logic          mem_write,
  output logic [1:0]    mem_size,
  output logic [3:0]    mem_sel,
  output logic [DW-1:0] mem_st_data,
  input  logic          mem_ready,
  output logic          grant_d
);
  arb_state_e state, state_nxt;
  logic       pick_valid, pick_gnt;
  logic       load, done;

`ifdef ARB_RR_EN
  logic last_grant;
`endif

  mem_arb_pick u_pick (
    .req_i      (i_strobe),
    .req_d      (d_strobe & ~flush),
`ifdef ARB_RR_EN
    .last_grant (last_grant),
`endif
    .valid      (pick_valid),
    .gnt        (pick_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (pick_valid) begin
        load      = 1'b1;
        state_nxt = (pick_gnt == GNT_D) ? ST_BUSY_D : ST_BUSY_I;
      end
      ST_BUSY_I, ST_BUSY_D: if (mem_ready) begin
        done      = 1'b1;
        state_nxt = ST_TURN;
      end
      // Served cache gets one cycle to drop its strobe before re-arbitration.
      ST_TURN: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_access  <= 1'b0;
      mem_a       <= '0;
      mem_write   <= 1'b0;
      mem_size    <= '0;
      mem_sel     <= '0;
      mem_st_data <= '0;
    end else if (load) begin
      mem_access <= 1'b1;
      if (pick_gnt == GNT_D) begin
        mem_a       <= d_addr;
        mem_write   <= d_rw;
        mem_size    <= d_size;
        mem_sel     <= d_sel;
        mem_st_data <= d_wdata;
      end else begin
        mem_a       <= i_addr;
        mem_write   <= 1'b0;
        mem_size    <= SIZE_WORD;
        mem_sel     <= SEL_ALL;
        mem_st_data <= '0;
      end
    end else if (done) begin
      mem_access <= 1'b0;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst)       last_grant <= GNT_I;
    else if (load) last_grant <= pick_gnt;
  end
`endif

  // Completion is steered only to the current owner; stray mem_ready is dropped.
  assign i_ready = (state == ST_BUSY_I) & mem_ready;
  assign d_ready = (state == ST_BUSY_D) & mem_ready;
  assign grant_d = (state == ST_BUSY_D);
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed cases plus random traffic vs. a behavioural model.
module tb_mem_req_arbiter;
  logic        clk = 1'b0;
  logic        rst, i_strobe, d_strobe, d_rw, flush, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_size;
  logic [3:0]  d_sel;
  logic        i_ready, d_ready, mem_access, mem_write, grant_d;
  logic [31:0] mem_a, mem_st_data;
  logic [1:0]  mem_size;
  logic [3:0]  mem_sel;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .i_strobe(i_strobe), .i_addr(i_addr), .i_ready(i_ready),
    .d_strobe(d_strobe), .d_rw(d_rw), .d_addr(d_addr), .d_size(d_size),
    .d_sel(d_sel), .d_wdata(d_wdata), .d_ready(d_ready), .flush(flush),
    .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write),
    .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
    .mem_ready(mem_ready), .grant_d(grant_d)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: who owns the slave, whether we are in the post-access gap,
  // and a snapshot of the request handed to the slave.
  int          m_owner = 0;   // 0 none, 1 icache, 2 dcache
  bit          m_gap   = 1'b0;
  bit          m_last  = 1'b0; // 0 icache, 1 dcache
  logic        m_acc = 1'b0, m_wr = 1'b0;
  logic [31:0] m_a = '0, m_wd = '0;
  logic [1:0]  m_sz = '0;
  logic [3:0]  m_sel = '0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_owner = 0; m_gap = 0; m_last = 0;
        m_acc = 0; m_wr = 0; m_a = '0; m_wd = '0; m_sz = '0; m_sel = '0;
      end else if (m_owner != 0) begin
        if (mem_ready) begin
          m_owner = 0; m_gap = 1; m_acc = 0;
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else begin
        bit ci, cd, win_d;
        ci = i_strobe;
        cd = d_strobe && !flush;
        if (ci || cd) begin
`ifdef ARB_RR_EN
          win_d = (ci && cd) ? !m_last : cd;
`else
          win_d = cd;
`endif
          if (win_d) begin
            m_owner = 2; m_a = d_addr; m_wr = d_rw; m_sz = d_size; m_sel = d_sel; m_wd = d_wdata;
          end else begin
            m_owner = 1; m_a = i_addr; m_wr = 0; m_sz = 2; m_sel = 4'hF; m_wd = 0;
          end
          m_last = win_d;
          m_acc  = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("i_ready",     i_ready,     (m_owner == 1) && mem_ready);
        chk("d_ready",     d_ready,     (m_owner == 2) && mem_ready);
        chk("grant_d",     grant_d,     m_owner == 2);
        chk("mem_access",  mem_access,  m_acc);
        chk("mem_a",       mem_a,       m_a);
        chk("mem_write",   mem_write,   m_wr);
        chk("mem_size",    mem_size,    m_sz);
        chk("mem_sel",     mem_sel,     m_sel);
        chk("mem_st_data", mem_st_data, m_wd);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    i_strobe = 0; d_strobe = 0; d_rw = 0; flush = 0; mem_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_size = '0; d_sel = '0;
  endtask

  initial begin
    clear_in();
    rst = 1;
    step(); step();
    @(negedge clk);
    chk("rst_access", mem_access, 0);
    chk("rst_a", mem_a, 0);
    chk("rst_size", mem_size, 0);
    chk("rst_ready", {i_ready, d_ready, grant_d}, 0);
    chk_en = 1;
    step();

    // single icache miss: strobe in cycle 0, mem_ready in cycle 5
    rst = 0; i_strobe = 1; i_addr = 32'hBFC00000;
    step();
    @(negedge clk);
    chk("ic_access", mem_access, 1);
    chk("ic_a", mem_a, 32'hBFC00000);
    chk("ic_size_sel_wr", {mem_size, mem_sel, mem_write}, {2'd2, 4'hF, 1'b0});
    step(); step(); step(); step();
    mem_ready = 1;
    @(negedge clk);
    chk("ic_iready", i_ready, 1);
    chk("ic_dready", d_ready, 0);
    step();
    mem_ready = 0; i_strobe = 0;
    @(negedge clk);
    chk("ic_turn_access", mem_access, 0);
    step();

    // dcache store
    d_strobe = 1; d_rw = 1; d_addr = 32'h1FAF0000; d_size = 0; d_sel = 4'b0010; d_wdata = 32'h0000AB00;
    step();
    @(negedge clk);
    chk("ds_a", mem_a, 32'h1FAF0000);
    chk("ds_fields", {mem_write, mem_size, mem_sel}, {1'b1, 2'd0, 4'b0010});
    chk("ds_wdata", mem_st_data, 32'h0000AB00);
    step();
    mem_ready = 1;
    @(negedge clk);
    chk("ds_dready", d_ready, 1);
    chk("ds_iready", i_ready, 0);
    step();
    clear_in();
    step();

    // tie straight out of reset: dcache first, icache after TURN + IDLE
    rst = 1;
    step();
    rst = 0; i_strobe = 1; i_addr = 32'h100; d_strobe = 1; d_addr = 32'h200;
    step();
    @(negedge clk);
    chk("tie_first_d", grant_d, 1);
    chk("tie_first_a", mem_a, 32'h200);
    step();
    mem_ready = 1;
    @(negedge clk);
    chk("tie_dready", d_ready, 1);
    step();
    mem_ready = 0; d_strobe = 0;
    @(negedge clk);
    chk("tie_turn", mem_access, 0);
    step();
    @(negedge clk);
    chk("tie_idle", mem_access, 0);
    step();
    @(negedge clk);
    chk("tie_second_i", {mem_access, grant_d}, 2'b10);
    chk("tie_second_a", mem_a, 32'h100);
    mem_ready = 1;
    step();
    clear_in();
    step();
    // second tie: winner left to the model
    i_strobe = 1; d_strobe = 1; i_addr = 32'h110; d_addr = 32'h210;
    step(); step();
    mem_ready = 1;
    step();
    clear_in();
    step(); step();

    // flush blocks a new dcache grant but not one in flight
    d_strobe = 1; flush = 1; d_addr = 32'h300;
    step(); step(); step();
    @(negedge clk);
    chk("flush_nogrant", mem_access, 0);
    flush = 0;
    step();
    @(negedge clk);
    chk("flush_release", mem_access, 1);
    flush = 1;
    step();
    mem_ready = 1;
    @(negedge clk);
    chk("flush_busy_dready", d_ready, 1);
    step();
    clear_in();
    step();

    // stray mem_ready in IDLE, then request fields changed mid-access
    mem_ready = 1;
    @(negedge clk);
    chk("stray_ready", {i_ready, d_ready}, 0);
    step();
    mem_ready = 0;
    @(negedge clk);
    chk("stray_access", mem_access, 0);
    i_strobe = 1; i_addr = 32'h400;
    step();
    i_addr = 32'h999; d_strobe = 1; d_addr = 32'h888;
    step();
    @(negedge clk);
    chk("frozen_a", mem_a, 32'h400);
    chk("frozen_owner", grant_d, 0);
    mem_ready = 1;
    step();
    clear_in();
    step(); step();

    // reset in the middle of a dcache access
    d_strobe = 1; d_addr = 32'h500;
    step();
    rst = 1; d_strobe = 0;
    step();
    @(negedge clk);
    chk("rstmid_access", mem_access, 0);
    chk("rstmid_flags", {grant_d, d_ready}, 0);
    rst = 0; i_strobe = 1; i_addr = 32'h600;
    step();
    @(negedge clk);
    chk("rstmid_next", {mem_access, mem_a}, {1'b1, 32'h600});
    mem_ready = 1;
    step();
    clear_in();
    step(); step();

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      i_strobe  = ($urandom % 2) == 0;
      d_strobe  = ($urandom % 2) == 0;
      d_rw      = $urandom % 2;
      flush     = ($urandom % 5) == 0;
      mem_ready = ($urandom % 4) == 0;
      rst       = ($urandom % 150) == 0;
      i_addr    = $urandom;
      d_addr    = $urandom;
      d_wdata   = $urandom;
      d_size    = $urandom_range(0, 2);
      d_sel     = $urandom;
      step();
    end
    clear_in();
    rst = 0;
    step(); step();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
